alu_mul_seq: RTL and testbench

Multi-cycle 32x32 -> 64-bit multiply sequencer for MULTU (and optionally MULT) that borrows the shared 32-bit ALU rather than owning a multiplier. It runs shift-add iterations and requests the ALU through a req/gnt pair only on iterations that need an add. HI/LO results feed the register-file HI/LO path. Sits beside the ALU, behind the ALU-port arbiter.

---
 rtl/alu_mul_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle 32x32 -> 64-bit multiply sequencer. It does not own an adder.
// Every add it needs is borrowed from the shared 32-bit ALU through a req/gnt
// handshake. Iterations that only shift never request the ALU. The HI/LO
// result words feed the register-file HI/LO path.
//
// The algorithm is classic right-shifting shift-add. {hi,lo} starts as
// {0, multiplier}. On each iteration, if lo[0] is set, the multiplicand is
// added into hi. The 65-bit {carry,hi,lo} is then shifted right by one. After
// ITER iterations {hi,lo} holds the product.
//
// Optional build macro: MUL_SIGNED_EN
//   When defined, this adds the signed_op input and the NEGA/NEGB/FIX states.
//   Negative operands are negated through the ALU (0 - x) before iterating.
//   The product is negated locally afterwards when the operand signs differ.
//   When undefined, all multiplies are unsigned.
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high reset
//   start       in   1   request a multiply (sampled only while not busy)
//   signed_op   in   1   signed multiply request (MUL_SIGNED_EN builds only)
//   op_a        in  32   multiplicand, captured on accept
//   op_b        in  32   multiplier, captured on accept
//   busy        out  1   operation in progress
//   done        out  1   one-cycle pulse, hi/lo valid
//   hi          out 32   upper product word, held until next accept
//   lo          out 32   lower product word, held until next accept
//   alu_req     out  1   sequencer needs the ALU this cycle
//   alu_gnt     in   1   ALU granted this cycle, result consumed same cycle
//   alu_op      out  4   ALU opcode
//   alu_in1     out 32   ALU operand 1
//   alu_in2     out 32   ALU operand 2
//   alu_result  in  32   combinational ALU result
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int         ITER       = 32,
`ifdef MUL_SIGNED_EN
    parameter logic [3:0] ALU_OP_SUB = 4'b0111,
`endif
    parameter logic [3:0] ALU_OP_ADD = 4'b0110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef MUL_SIGNED_EN
    input  logic        signed_op,
`endif
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result
);

    localparam int              CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ITER = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] S_NEGA = 3'd3;
    localparam logic [2:0] S_NEGB = 3'd4;
    localparam logic [2:0] S_FIX  = 3'd5;
`endif

    // Architectural state
    logic [2:0]    state_q, state_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;
    logic [31:0]   mcand_q, mcand_d;
    logic [CW-1:0] count_q, count_d;
`ifdef MUL_SIGNED_EN
    // Remember which operands were negated, so that the product sign can be
    // restored after the unsigned core finishes.
    logic          a_neg_q, a_neg_d;
    logic          b_neg_q, b_neg_d;
`endif

    // Combinational helpers
    logic          step;
    logic          carry;
    logic          req_c;
    logic [3:0]    op_c;
    logic [31:0]   in1_c;
    logic [31:0]   in2_c;
`ifdef MUL_SIGNED_EN
    logic [63:0]   neg_prod;
    assign neg_prod = ~{hi_q, lo_q} + 64'd1;
`endif

    // -------------------------------------------------------------------------
    // Next-state and ALU drive
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        count_d = count_q;
`ifdef MUL_SIGNED_EN
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
`endif
        step    = 1'b0;
        carry   = 1'b0;
        // The ALU inputs stay at a quiet add of zeros whenever the sequencer
        // does not own the ALU.
        req_c   = 1'b0;
        op_c    = ALU_OP_ADD;
        in1_c   = 32'd0;
        in2_c   = 32'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start so that multiplies can run
                // back-to-back. Otherwise it falls through to IDLE.
                state_d = S_IDLE;
                if (start) begin
                    mcand_d = op_a;
                    hi_d    = 32'd0;
                    lo_d    = op_b;
                    count_d = '0;
                    busy_d  = 1'b1;
`ifdef MUL_SIGNED_EN
                    a_neg_d = signed_op & op_a[31];
                    b_neg_d = signed_op & op_b[31];
                    if (signed_op & op_a[31]) begin
                        state_d = S_NEGA;
                    end else if (signed_op & op_b[31]) begin
                        state_d = S_NEGB;
                    end else begin
                        state_d = S_ITER;
                    end
`else
                    state_d = S_ITER;
`endif
                end
            end

`ifdef MUL_SIGNED_EN
            S_NEGA: begin
                req_c = 1'b1;
                op_c  = ALU_OP_SUB;
                in2_c = mcand_q;
                if (alu_gnt) begin
                    mcand_d = alu_result;
                    state_d = b_neg_q ? S_NEGB : S_ITER;
                end
            end

            S_NEGB: begin
                req_c = 1'b1;
                op_c  = ALU_OP_SUB;
                in2_c = lo_q;
                if (alu_gnt) begin
                    lo_d    = alu_result;
                    state_d = S_ITER;
                end
            end

            S_FIX: begin
                // Local two's-complement of the 64-bit magnitude. The ALU is
                // only 32 bits wide, so it cannot do this step.
                hi_d    = neg_prod[63:32];
                lo_d    = neg_prod[31:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
`endif

            S_ITER: begin
                if (lo_q[0]) begin
                    req_c = 1'b1;
                    in1_c = hi_q;
                    in2_c = mcand_q;
                    // Without a grant, every register holds and the request
                    // stays up.
                    if (alu_gnt) begin
                        // The ALU returns only 32 bits. The carry out of
                        // hi + mcand is recovered by the unsigned wrap test.
                        carry = (alu_result < hi_q);
                        hi_d  = {carry, alu_result[31:1]};
                        lo_d  = {alu_result[0], lo_q[31:1]};
                        step  = 1'b1;
                    end
                end else begin
                    hi_d = {1'b0, hi_q[31:1]};
                    lo_d = {hi_q[0], lo_q[31:1]};
                    step = 1'b1;
                end

                if (step) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
`ifdef MUL_SIGNED_EN
                        if (a_neg_q ^ b_neg_q) begin
                            state_d = S_FIX;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            mcand_q <= 32'd0;
            count_q <= '0;
`ifdef MUL_SIGNED_EN
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
`ifdef MUL_SIGNED_EN
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign alu_req = req_c;
    assign alu_op  = op_c;
    assign alu_in1 = in1_c;
    assign alu_in2 = in2_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Directed bench for alu_mul_seq. A small add/sub ALU model answers the
// sequencer's requests. A table of operand pairs with hand-computed products
// is run under a continuous grant. Hand-written sequences then cover grant
// stalls, mid-operation reset, start while busy, back-to-back start from DONE,
// and the signed path when MUL_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        alu_gnt = 1'b1;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
`ifdef MUL_SIGNED_EN
    logic        signed_op = 1'b0;
`endif
    wire         busy;
    wire         done;
    wire  [31:0] hi;
    wire  [31:0] lo;
    wire         alu_req;
    wire  [3:0]  alu_op;
    wire  [31:0] alu_in1;
    wire  [31:0] alu_in2;
    wire  [31:0] alu_result;

    int n_tests = 0;
    int n_fail  = 0;

    // Shared ALU stand-in: 0110 adds, 0111 subtracts.
    assign alu_result = (alu_op == 4'b0111) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

    alu_mul_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef MUL_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_op     (alu_op),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one multiply and wait for done.
    //   now   : drive start immediately instead of waiting for a negedge.
    //           This is used to start from inside the DONE cycle.
    //   stall : number of edges after accept during which the grant is low.
    //   poke  : edge index at which a second start is pulsed (-1 = never).
    // lat returns the edges from accept to done. busy_ok and req_ok collect
    // the checks that apply while the multiply is in flight.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit now,
                           input int stall, input int poke,
                           output int lat, output bit busy_ok, output bit req_ok);
        lat     = 0;
        busy_ok = 1'b1;
        req_ok  = 1'b1;
        if (!now) @(negedge clk);
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        alu_gnt = (stall == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!busy) busy_ok = 1'b0;
        forever begin
            @(posedge clk);
            lat++;
            #1;
            start = 1'b0;
            if (lat == stall) alu_gnt = 1'b1;
            if (lat < stall && !alu_req) req_ok = 1'b0;
            if (lat == poke) begin
                op_a  = ~a;
                op_b  = b + 32'd1;
                start = 1'b1;
            end
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (lat >= 200) begin
                lat = 999;
                break;
            end
        end
        alu_gnt = 1'b1;
    endtask

    initial begin
        int  lat;
        bit  bok;
        bit  rok;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[6] = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[7] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    {63'd0, busy},    64'd0);
        chk("rst_done",    {63'd0, done},    64'd0);
        chk("rst_hilo",    {hi, lo},         64'd0);
        chk("rst_req",     {63'd0, alu_req}, 64'd0);
        chk("idle_alu_op", {60'd0, alu_op},  64'h6);
        chk("idle_alu_in", {alu_in1, alu_in2}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of products with continuous grant
        for (int i = 0; i < 9; i++) begin
            run_mul(vecs[i].a, vecs[i].b, 1'b0, 0, -1, lat, bok, rok);
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd32);
            chk($sformatf("vec%0d_busy", i), {63'd0, bok}, 64'd1);
            chk($sformatf("vec%0d_busy_low", i), {63'd0, busy}, 64'd0);
        end

        // done is a single pulse, and the result holds while idle
        @(posedge clk);
        #1;
        chk("done_pulse", {63'd0, done}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

        // Grant withheld for the first four edges after accept
        run_mul(32'd7, 32'd3, 1'b0, 4, -1, lat, bok, rok);
        chk("stall_lat", 64'(lat), 64'd36);
        chk("stall_hilo", {hi, lo}, 64'd21);
        chk("stall_req_held", {63'd0, rok}, 64'd1);

        // Asynchronous reset at iteration 10
        @(negedge clk);
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_hi_nonzero", {63'd0, (hi != 32'd0)}, 64'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        run_mul(32'h0000_1234, 32'h0000_0100, 1'b0, 0, -1, lat, bok, rok);
        chk("post_rst_hilo", {hi, lo}, 64'h0000_0000_0012_3400);
        chk("post_rst_lat", 64'(lat), 64'd32);

        // Start pulsed mid-operation with different operands is ignored
        run_mul(32'd1000, 32'd1000, 1'b0, 0, 5, lat, bok, rok);
        chk("busy_start_hilo", {hi, lo}, 64'd1000000);
        chk("busy_start_lat", 64'(lat), 64'd32);

        // Start inside the DONE cycle is accepted back-to-back
        run_mul(32'h0000_0009, 32'h0000_000B, 1'b1, 0, -1, lat, bok, rok);
        chk("b2b_hilo", {hi, lo}, 64'd99);
        chk("b2b_lat", 64'(lat), 64'd32);
        chk("b2b_busy", {63'd0, bok}, 64'd1);

`ifdef MUL_SIGNED_EN
        // -3 * 7 : NEGA and FIX each add a cycle
        @(negedge clk);
        signed_op = 1'b1;
        run_mul(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 0, -1, lat, bok, rok);
        signed_op = 1'b0;
        chk("sgn_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("sgn_lat", 64'(lat), 64'd34);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
